// File: rtl/score_bcd_conv_pkg.sv
// Shared constants, FSM encoding and helpers for the score-to-BCD feeder.
// Widths here are the defaults; the top module re-exposes them as parameters.
package score_bcd_conv_pkg;

  localparam int       SCORE_W    = 10;
  localparam int       DIGITS     = 3;
  localparam logic [3:0] BLANK_CODE = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  // Largest value representable in n decimal digits (10^n - 1).
  function automatic int unsigned max_score(input int n);
    int unsigned v;
    v = 1;
    for (int i = 0; i < n; i++) begin
      v = v * 10;
    end
    return v - 1;
  endfunction

endpackage

// File: rtl/score_bcd_conv_bcd_add3_stage.sv
// Combinational double-dabble correction: each BCD nibble >= 5 gets +3
// so that the following left shift carries correctly into the next digit.
module bcd_add3_stage #(
  parameter int DIGITS = 3
) (
  input  logic [4*DIGITS-1:0] bcd_in,
  output logic [4*DIGITS-1:0] bcd_out
);

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
    assign bcd_out[4*gi +: 4] = (bcd_in[4*gi +: 4] >= 4'd5) ? (bcd_in[4*gi +: 4] + 4'd3)
                                                            : bcd_in[4*gi +: 4];
  end

endmodule

// File: rtl/score_bcd_conv.sv
// Per-frame binary score to BCD converter with frame-stable committed digits
// and a registered, leading-zero-blanking per-digit read port.
module score_bcd_conv
  import score_bcd_conv_pkg::*;
#(
  parameter int         SCORE_W    = score_bcd_conv_pkg::SCORE_W,
  parameter int         DIGITS     = score_bcd_conv_pkg::DIGITS,
  parameter int         LZ_BLANK   = 1,
  parameter logic [3:0] BLANK_CODE = score_bcd_conv_pkg::BLANK_CODE
) (
  input  logic                  vga_clk,
  input  logic                  sys_rst,
  input  logic                  frame_start,
  input  logic [SCORE_W-1:0]    score,
  output logic                  busy,
  output logic                  done,
  input  logic [1:0]            dig_sel,
  output logic [3:0]            dig_out,
  output logic [4*DIGITS-1:0]   digits_flat
);

  localparam int          BCD_W   = 4*DIGITS;
  localparam int          SR_W    = BCD_W + SCORE_W;
  localparam int          CNT_W   = $clog2(SCORE_W+1);
  localparam int unsigned SAT_VAL = max_score(DIGITS);

  state_t             state_q, state_d;
  logic [SR_W-1:0]    sr_q, sr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BCD_W-1:0]   digits_q, digits_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [3:0]         dig_out_q, dig_out_d;

  logic [BCD_W-1:0]   bcd_adj;
  logic [SCORE_W-1:0] score_sat;
  logic [3:0]         digit_arr [DIGITS];
  logic [DIGITS-1:0]  lz;

  bcd_add3_stage #(.DIGITS(DIGITS)) u_add3 (
    .bcd_in  (sr_q[SR_W-1 -: BCD_W]),
    .bcd_out (bcd_adj)
  );

  // Saturate at full input width so large scores never wrap into the BCD range.
  always_comb begin
    score_sat = score;
    if (32'(score) > SAT_VAL) begin
      score_sat = SCORE_W'(SAT_VAL);
    end
  end

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    digits_d = digits_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          sr_d    = {{BCD_W{1'b0}}, score_sat};
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sr_d  = {bcd_adj[BCD_W-2:0], sr_q[SCORE_W-1:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(SCORE_W-1)) begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        digits_d = sr_q[SR_W-1 -: BCD_W];
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // digit_arr[0] is the most significant digit; lz[i] means digits 0..i are all zero.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_dig
    assign digit_arr[gi] = digits_q[4*(DIGITS-1-gi) +: 4];
    if (gi == 0) begin : g_lz0
      assign lz[gi] = (digit_arr[gi] == 4'd0);
    end else begin : g_lzn
      assign lz[gi] = lz[gi-1] & (digit_arr[gi] == 4'd0);
    end
  end

  always_comb begin
    dig_out_d = BLANK_CODE;
    for (int i = 0; i < DIGITS; i++) begin
      if (int'(dig_sel) == i) begin
        if ((LZ_BLANK != 0) && (i < DIGITS-1) && lz[i]) begin
          dig_out_d = BLANK_CODE;
        end else begin
          dig_out_d = digit_arr[i];
        end
      end
    end
  end

  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      state_q   <= ST_IDLE;
      sr_q      <= '0;
      cnt_q     <= '0;
      digits_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dig_out_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      digits_q  <= digits_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dig_out_q <= dig_out_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign dig_out     = dig_out_q;
  assign digits_flat = digits_q;

endmodule

// File: tb/tb_score_bcd_conv.sv
// Scoreboard bench for score_bcd_conv: expected digits are queued at each
// accepted frame_start and compared when done pulses.
module tb_score_bcd_conv;

  logic        clk;
  logic        sys_rst;
  logic        frame_start;
  logic [9:0]  score;
  logic        busy;
  logic        done;
  logic [1:0]  dig_sel;
  logic [3:0]  dig_out;
  logic [11:0] digits_flat;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [11:0] exp_q [$];
  logic [11:0] last_flat = 12'h000;

  score_bcd_conv dut (
    .vga_clk     (clk),
    .sys_rst     (sys_rst),
    .frame_start (frame_start),
    .score       (score),
    .busy        (busy),
    .done        (done),
    .dig_sel     (dig_sel),
    .dig_out     (dig_out),
    .digits_flat (digits_flat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  function automatic logic [11:0] model(input int s);
    int v;
    v = (s > 999) ? 999 : s;
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [3:0] exp_dig(input int sel, input logic [11:0] f);
    int v;
    v = int'(f[11:8]) * 100 + int'(f[7:4]) * 10 + int'(f[3:0]);
    case (sel)
      0:       return (v < 100) ? 4'hF : f[11:8];
      1:       return (v < 10)  ? 4'hF : f[7:4];
      2:       return f[3:0];
      default: return 4'hF;
    endcase
  endfunction

  // Called on a falling edge; returns on the falling edge after the sampling edge.
  task automatic start_frame(input int s, input bit push);
    score       = 10'(s);
    frame_start = 1'b1;
    if (push) exp_q.push_back(model(s));
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int busy_cyc, output bit timeout);
    lat = 0; busy_cyc = 0; timeout = 1'b0;
    while (!done) begin
      if (busy) busy_cyc++;
      if (lat >= 60) begin
        timeout = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    sys_rst = 1'b1; frame_start = 1'b0; score = '0; dig_sel = 2'd0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || digits_flat !== 12'h000 || dig_out !== 4'h0) begin
      errors++;
      $display("FAIL reset_state busy=%b done=%b flat=%h dig=%h required 0 0 000 0",
               busy, done, digits_flat, dig_out);
    end
    sys_rst = 1'b0;
    for (int s = 0; s < 4; s++) begin
      dig_sel = 2'(s);
      @(negedge clk);
      checks++;
      if (dig_out !== exp_dig(s, 12'h000)) begin
        errors++;
        $display("FAIL reset_read sel=%0d got=%h required=%h", s, dig_out, exp_dig(s, 12'h000));
      end
    end
    repeat (5) @(negedge clk);
    checks++;
    if (done_cnt !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle done_cnt=%0d busy=%b required 0 0", done_cnt, busy);
    end
    $display("reset: flat=%h", digits_flat);
  endtask

  task automatic test_convert(input int s);
    int lat, bc, d0;
    bit to;
    logic [11:0] e;
    d0 = done_cnt;
    start_frame(s, 1'b1);
    wait_done(lat, bc, to);
    checks++;
    if (to || lat != 11 || bc != 11) begin
      errors++;
      $display("FAIL conv_timing score=%0d lat=%0d busy_cycles=%0d timeout=%b required 11 11 0",
               s, lat, bc, to);
    end
    e = exp_q.pop_front();
    checks++;
    if (digits_flat !== e) begin
      errors++;
      $display("FAIL conv_digits score=%0d got=%h required=%h", s, digits_flat, e);
    end
    last_flat = e;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || done_cnt != d0 + 1) begin
      errors++;
      $display("FAIL conv_pulse score=%0d done=%b busy=%b pulses=%0d required 0 0 1",
               s, done, busy, done_cnt - d0);
    end
    for (int k = 0; k < 4; k++) begin
      dig_sel = 2'(k);
      @(negedge clk);
      checks++;
      if (dig_out !== exp_dig(k, e)) begin
        errors++;
        $display("FAIL conv_read score=%0d sel=%0d got=%h required=%h", s, k, dig_out, exp_dig(k, e));
      end
    end
    $display("convert: score=%0d flat=%h lat=%0d", s, digits_flat, lat);
  endtask

  task automatic test_ignore_busy;
    int lat, bc, d0;
    bit to;
    logic [11:0] e;
    d0 = done_cnt;
    start_frame(437, 1'b1);
    repeat (2) @(negedge clk);
    start_frame(12, 1'b0);
    wait_done(lat, bc, to);
    e = exp_q.pop_front();
    checks++;
    if (to || digits_flat !== e) begin
      errors++;
      $display("FAIL ignore_busy got=%h required=%h timeout=%b", digits_flat, e, to);
    end
    last_flat = e;
    repeat (20) @(negedge clk);
    checks++;
    if (done_cnt != d0 + 1 || digits_flat !== e) begin
      errors++;
      $display("FAIL ignore_queued pulses=%0d flat=%h required 1 %h", done_cnt - d0, digits_flat, e);
    end
    $display("ignore: flat=%h", digits_flat);
    test_convert(12);
  endtask

  task automatic test_reset_abort;
    int lat, bc, d0;
    bit to;
    logic [11:0] e;
    test_convert(1023);
    d0 = done_cnt;
    start_frame(500, 1'b0);
    repeat (4) @(negedge clk);
    sys_rst = 1'b1;
    @(negedge clk);
    sys_rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || digits_flat !== 12'h000 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_state busy=%b flat=%h done=%b required 0 000 0", busy, digits_flat, done);
    end
    last_flat = 12'h000;
    repeat (20) @(negedge clk);
    checks++;
    if (done_cnt != d0 || digits_flat !== 12'h000) begin
      errors++;
      $display("FAIL abort_no_done pulses=%0d flat=%h required 0 000", done_cnt - d0, digits_flat);
    end
    $display("abort: flat=%h", digits_flat);
    start_frame(250, 1'b1);
    wait_done(lat, bc, to);
    e = exp_q.pop_front();
    checks++;
    if (to || digits_flat !== e) begin
      errors++;
      $display("FAIL abort_recover got=%h required=%h timeout=%b", digits_flat, e, to);
    end
    last_flat = e;
    @(negedge clk);
    $display("recover: flat=%h", digits_flat);
  endtask

  task automatic test_no_trigger;
    int d0, sel;
    d0 = done_cnt;
    for (int i = 0; i < 100; i++) begin
      score = 10'($urandom_range(0, 1023));
      sel = $urandom_range(0, 3);
      dig_sel = 2'(sel);
      @(negedge clk);
      checks++;
      if (digits_flat !== last_flat || dig_out !== exp_dig(sel, last_flat)) begin
        errors++;
        $display("FAIL no_trigger i=%0d flat=%h dig=%h required %h %h",
                 i, digits_flat, dig_out, last_flat, exp_dig(sel, last_flat));
      end
    end
    checks++;
    if (done_cnt != d0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL no_trigger_done pulses=%0d busy=%b required 0 0", done_cnt - d0, busy);
    end
    $display("no_trigger: flat=%h", digits_flat);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_convert(437);
    test_convert(1023);
    test_convert(7);
    test_convert(0);
    test_ignore_busy();
    test_reset_abort();
    test_no_trigger();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left entries=%0d required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/score_bcd_conv.md
Name: score_bcd_conv

Overview:
- Upstream feeder for the end-of-game page.
- Samples the binary game score once per frame and converts it to decimal digits with a sequential shift-add-3 (double-dabble) engine.
- Holds the digits stable for the whole frame so the display never tears.
- Serves a registered per-digit read port that the page renderer indexes by digit position while scanning the SCORE box.

Parameters:
- SCORE_W, 10, width of the binary score input.
- DIGITS, 3, number of decimal digits produced; saturation value is 10^DIGITS-1 (999).
- LZ_BLANK, 1, when 1, leading zeros are reported as the blank code.
- BLANK_CODE, 4'hF, code returned for blank or out-of-range digit positions.

Ports:
- vga_clk  in  1  pixel clock; all logic on rising edge.
- sys_rst  in  1  synchronous active-high reset.
- frame_start  in  1  one-cycle pulse at start of vertical blank; triggers a conversion.
- score  in  SCORE_W  binary score, sampled only on an accepted frame_start.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse when new digits are committed.
- dig_sel  in  2  digit position to read; 0 = most significant.
- dig_out  out  4  BCD value or BLANK_CODE for dig_sel; 1-cycle registered latency.
- digits_flat  out  4*DIGITS  committed digits, MSD in the top nibble.

Behaviour:
- Reset: when sys_rst is sampled high, state=IDLE, shift register=0, counter=0, committed digits=0, busy=0, done=0, dig_out=0. Reset overrides everything and aborts any conversion in progress; committed digits are also cleared.
- FSM states: IDLE, SHIFT, COMMIT.
- IDLE: on an edge with frame_start=1:
  - load the shift register with min(score, 999) in the binary field and zero BCD fields;
  - counter=0, busy=1, go to SHIFT.
- SHIFT, one bit per edge:
  - every BCD nibble >=5 gets +3 (combinational, same cycle), then the whole register shifts left 1;
  - after SCORE_W shifts, go to COMMIT.
- COMMIT:
  - committed digits <= BCD fields; done=1 for exactly this one cycle;
  - busy=0, return to IDLE.
- Latency: sample edge E0; shifts on E1..E_SCORE_W; commit on E_(SCORE_W+1). done is high and new digits_flat are visible in the cycle after E_(SCORE_W+1), which is 11 edges after E0 by default.
- frame_start while busy or in COMMIT is ignored and not queued.
- A score change without frame_start has no effect.
- Saturation: score > 999 converts as 999. Comparison is done at full SCORE_W width before loading.
- Read port: dig_out <= f(dig_sel, committed digits) every edge, independent of FSM state, so it always reflects the last commit:
  - dig_sel >= DIGITS returns BLANK_CODE.
  - If LZ_BLANK=1, a digit is blank when it and all more-significant digits are 0. The least significant digit is never blanked, so score 0 reads as blank, blank, 0.
- Digits never change except at COMMIT or reset, so a frame is never mixed.
- Shift register width is 4*DIGITS+SCORE_W. Counter width is clog2(SCORE_W+1).

Decomposition:
- Shared package (define.vh alongside VGA_WIDTH/HEIGHT):
  - BLANK_CODE;
  - DIGITS;
  - SCORE_W;
  - FSM state encodings (2-bit localparams).
- One natural sub-module: bcd_add3_stage. It is combinational; it applies the conditional +3 to all DIGITS nibbles and is instantiated once inside the SHIFT datapath.
- Read-port blanking logic stays inline.

Test Plan:
- Reset then idle: dig_sel=0,1,2,3 -> dig_out=F,F,0,F one cycle later; busy=0, done never pulses.
- score=437, frame_start pulse -> busy high for 11 cycles, done pulses once; digits_flat=12'h437; dig_sel 0/1/2 -> 4,3,7.
- score=1023 -> digits_flat=12'h999. score=7 -> dig_sel 0/1/2 -> F,F,7.
- Second frame_start issued 3 cycles into a conversion with score changed 437->12 -> ignored; result 437; the next frame_start after done yields F,1,2.
- sys_rst asserted during SHIFT (cycle 5) after a prior committed 999 -> next cycle busy=0, digits_flat=0, no done pulse. A new frame_start with 250 then gives 12'h250.
- score changes every cycle with no frame_start for 100 cycles -> digits_flat and dig_out unchanged.
